pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 85 ++++++++
 tb/tb_pll_reset_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: synchronises PLL lock, holds it stable, then releases decode and CPU resets in staggered order.
// Define PLL_RESET_LOSS_COUNT_EN to add the saturating o_loss_count port.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 1024,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_locked,
  output logic       o_reset_decode,
  output logic       o_reset_cpu,
  output logic       o_ready,
  output logic [1:0] o_state
`ifdef PLL_RESET_LOSS_COUNT_EN
  ,
  output logic [7:0] o_loss_count
`endif
);
  typedef enum logic [1:0] {WAIT_LOCK = 2'b00, HOLD = 2'b01, STAGGER = 2'b10, RUN = 2'b11} state_t;
  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] STAGGER_LAST = 16'(STAGGER_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [15:0]            r_cnt;
  logic                   r_reset_decode;
  logic                   r_reset_cpu;
  logic                   r_ready;
  state_t                 w_next;
  logic [15:0]            w_cnt_next;
  logic                   w_lock_s;
  logic                   w_term;
  logic                   w_loss;
  assign w_lock_s = r_sync[SYNC_STAGES-1];
  assign w_term   = (r_state == HOLD) ? (r_cnt == HOLD_LAST) : (r_cnt == STAGGER_LAST);
  assign w_loss   = !w_lock_s && (r_state == STAGGER || r_state == RUN);
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_locked};
  // Lock loss takes priority over terminal count in both counting states.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    case (r_state)
      WAIT_LOCK: w_next = w_lock_s ? HOLD : WAIT_LOCK;
      HOLD: begin
        w_next     = !w_lock_s ? WAIT_LOCK : w_term ? STAGGER : HOLD;
        w_cnt_next = (w_lock_s && !w_term) ? r_cnt + 16'd1 : '0;
      end
      STAGGER: begin
        w_next     = !w_lock_s ? WAIT_LOCK : w_term ? RUN : STAGGER;
        w_cnt_next = (w_lock_s && !w_term) ? r_cnt + 16'd1 : '0;
      end
      default: w_next = w_lock_s ? RUN : WAIT_LOCK;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state        <= WAIT_LOCK;
      r_cnt          <= '0;
      r_reset_decode <= 1'b1;
      r_reset_cpu    <= 1'b1;
      r_ready        <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cnt          <= w_cnt_next;
      r_reset_decode <= !(w_next == STAGGER || w_next == RUN);
      r_reset_cpu    <= w_next != RUN;
      r_ready        <= w_next == RUN;
    end
  assign o_reset_decode = r_reset_decode;
  assign o_reset_cpu    = r_reset_cpu;
  assign o_ready        = r_ready;
  assign o_state        = r_state;
`ifdef PLL_RESET_LOSS_COUNT_EN
  logic [7:0] r_loss_count;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset)                            r_loss_count <= '0;
    else if (w_loss && r_loss_count != 8'hff) r_loss_count <= r_loss_count + 8'd1;
  assign o_loss_count = r_loss_count;
`else
  logic w_unused;
  assign w_unused = w_loss;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scoreboard bench; every observed output change is matched against a queued expected event.
module tb_pll_reset_sequencer;
  typedef struct packed {
    int         e;
    logic [1:0] st;
    logic       rd;
    logic       rc;
    logic       rdy;
    logic [7:0] lc;
  } ev_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       reset_decode, reset_cpu, ready;
  logic [1:0] state;
  logic [7:0] lc_obs;
  int         edge_n = 0;
  int         errors = 0;
  int         checks = 0;
  int         exp_lc = 0;
  ev_t        q[$];
  pll_reset_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(8), .STAGGER_CYCLES(4)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_locked(locked),
    .o_reset_decode(reset_decode),
    .o_reset_cpu(reset_cpu),
    .o_ready(ready),
    .o_state(state)
`ifdef PLL_RESET_LOSS_COUNT_EN
    ,
    .o_loss_count(lc_obs)
`endif
  );
`ifndef PLL_RESET_LOSS_COUNT_EN
  assign lc_obs = 8'd0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  task automatic push(input int e, input logic [1:0] st);
    ev_t v;
    v.e   = e;
    v.st  = st;
    v.rd  = (st == 2'b00 || st == 2'b01);
    v.rc  = (st != 2'b11);
    v.rdy = (st == 2'b11);
`ifdef PLL_RESET_LOSS_COUNT_EN
    v.lc  = 8'(exp_lc);
`else
    v.lc  = 8'd0;
`endif
    q.push_back(v);
  endtask
  task automatic at_edge(input int n);
    do @(negedge clk); while (edge_n < n);
    #1;
  endtask
  task automatic lose();
    exp_lc = (exp_lc < 255) ? exp_lc + 1 : 255;
  endtask
  // Monitor: any change of the output vector is a DUT event to be matched.
  logic [12:0] prev;
  logic        first = 1'b1;
  always @(negedge clk) begin
    logic [12:0] cur;
    ev_t         x;
    cur = {state, reset_decode, reset_cpu, ready, lc_obs};
    if (first || cur != prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: edge=%0d got state=%b rd=%b rc=%b rdy=%b lc=%0d, none expected",
                 edge_n, state, reset_decode, reset_cpu, ready, lc_obs);
      end else begin
        x = q.pop_front();
        if (x.e != edge_n || cur != {x.st, x.rd, x.rc, x.rdy, x.lc}) begin
          errors++;
          $display("FAIL event: got edge=%0d state=%b rd=%b rc=%b rdy=%b lc=%0d, expected edge=%0d state=%b rd=%b rc=%b rdy=%b lc=%0d",
                   edge_n, state, reset_decode, reset_cpu, ready, lc_obs, x.e, x.st, x.rd, x.rc, x.rdy, x.lc);
        end
      end
    end
    prev  = cur;
    first = 1'b0;
  end
  initial begin
    int b;
    #1 rst = 1'b1;
    push(1, 2'b00);
    at_edge(2);   rst = 1'b0;
    at_edge(6);   locked = 1'b1; push(9, 2'b01); push(17, 2'b10); push(21, 2'b11);
    at_edge(25);  locked = 1'b0; lose(); push(28, 2'b00);
    at_edge(30);  locked = 1'b1; push(33, 2'b01); push(41, 2'b10); push(45, 2'b11);
    at_edge(50);  locked = 1'b0; lose(); push(53, 2'b00);
    at_edge(55);  locked = 1'b1; push(58, 2'b01);
    at_edge(60);  locked = 1'b0; push(63, 2'b00);
    at_edge(61);  locked = 1'b1; push(64, 2'b01); push(72, 2'b10); push(76, 2'b11);
    at_edge(80);  locked = 1'b0; lose(); push(83, 2'b00);
    at_edge(85);  locked = 1'b1; push(88, 2'b01); push(96, 2'b10);
    at_edge(98);  rst = 1'b1; exp_lc = 0; push(99, 2'b00);
    at_edge(99);  rst = 1'b0; push(102, 2'b01); push(110, 2'b10); push(114, 2'b11);
    at_edge(118); locked = 1'b0; lose(); push(121, 2'b00);
    at_edge(122); locked = 1'b1; push(125, 2'b01);
    at_edge(130); locked = 1'b0; push(133, 2'b00);
    at_edge(135); locked = 1'b1; push(138, 2'b01); push(146, 2'b10);
    at_edge(147); locked = 1'b0; lose(); push(150, 2'b00);
    at_edge(152); locked = 1'b1; push(155, 2'b01); push(163, 2'b10); push(167, 2'b11);
    b = 170;
    for (int i = 0; i < 300; i++) begin
      at_edge(b);     locked = 1'b0; lose(); push(b + 3, 2'b00);
      at_edge(b + 4); locked = 1'b1; push(b + 7, 2'b01); push(b + 15, 2'b10); push(b + 19, 2'b11);
      b += 20;
    end
    at_edge(b + 5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, expected 0 (next edge=%0d)", q.size(), q[0].e);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
